// File: rtl/uart_rx_frontend.sv
// UART receive front end: pad synchronizer, 3-sample majority filter with
// start-edge detect, and the divisor-driven 16x oversampling tick generator.
`timescale 1ns/1ps
module uart_rx_frontend #(
  parameter int SYNC_STAGES = 2,
  parameter int DL_W        = 16
) (
  input  logic            clk,
  input  logic            wb_rst_i,
  input  logic            srx_pad_i,
  input  logic [DL_W-1:0] dl,
  input  logic            dl_load,
  output logic            srx_filt,
  output logic            srx_fall,
  output logic            enable,
  output logic [3:0]      tick_cnt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_sync;
  logic                   h0_q, h0_d;
  logic                   h1_q, h1_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q, filt_prev_d;
  logic [DL_W-1:0]        cnt_q, cnt_d;
  logic                   enable_q, enable_d;
  logic [3:0]             tick_q, tick_d;
  logic [DL_W-1:0]        dl_m1;

  assign s_sync = sync_q[SYNC_STAGES-1];

  // Synchronizer and majority filter; a lone sample can never outvote two others.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], srx_pad_i};
    h0_d        = s_sync;
    h1_d        = h0_q;
    filt_d      = (s_sync & h0_q) | (s_sync & h1_q) | (h0_q & h1_q);
    filt_prev_d = filt_q;
  end

  // Reload value, guarded so a zero divisor never wraps to all ones.
  assign dl_m1 = (dl == '0) ? '0 : dl - DL_W'(1);

  always_comb begin
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    if (dl_load) begin
      cnt_d    = dl_m1;
      enable_d = 1'b0;
    end else if (dl == '0) begin
      cnt_d    = '0;
      enable_d = 1'b0;
    end else if (cnt_q == '0) begin
      cnt_d    = dl_m1;
      enable_d = 1'b1;
    end else begin
      cnt_d    = cnt_q - DL_W'(1);
    end
    tick_d = tick_q + {3'b000, enable_d};
  end

  always_ff @(posedge clk) begin
    if (wb_rst_i) begin
      sync_q      <= '1;
      h0_q        <= 1'b1;
      h1_q        <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      cnt_q       <= '0;
      enable_q    <= 1'b0;
      tick_q      <= '0;
    end else begin
      sync_q      <= sync_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      cnt_q       <= cnt_d;
      enable_q    <= enable_d;
      tick_q      <= tick_d;
    end
  end

  // The previous-value copy resets high, so no fall pulse follows reset.
  assign srx_filt = filt_q;
  assign srx_fall = filt_prev_q & ~filt_q;
  assign enable   = enable_q;
  assign tick_cnt = tick_q;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Bench for uart_rx_frontend: filter latency/glitch behaviour, start-edge
// pulses, baud tick period under divisor loads, and reset behaviour.
`timescale 1ns/1ps
module tb_uart_rx_frontend;

  localparam int DL_W = 16;

  logic            clk = 1'b0;
  logic            clk_run = 1'b1;
  logic            wb_rst_i;
  logic            srx_pad_i;
  logic [DL_W-1:0] dl;
  logic            dl_load;
  logic            srx_filt;
  logic            srx_fall;
  logic            enable;
  logic [3:0]      tick_cnt;

  logic [0:0]      exp_q[$];
  logic [3:0]      exp_tick;
  int              checks = 0;
  int              errors = 0;

  uart_rx_frontend #(.SYNC_STAGES(2), .DL_W(DL_W)) dut (
    .clk      (clk),
    .wb_rst_i (wb_rst_i),
    .srx_pad_i(srx_pad_i),
    .dl       (dl),
    .dl_load  (dl_load),
    .srx_filt (srx_filt),
    .srx_fall (srx_fall),
    .enable   (enable),
    .tick_cnt (tick_cnt)
  );

  // Clock with a run gate so reset can be applied while the clock is stopped.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pad(input logic pad_v, input logic exp_v);
    srx_pad_i = pad_v;
    exp_q.push_back(exp_v);
    tick_clk();
  endtask

  task automatic load_dl(input logic [DL_W-1:0] v);
    dl      = v;
    dl_load = 1'b1;
    tick_clk();
    dl_load = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; dl = '0; dl_load = 1'b0; srx_pad_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick_clk();
      checks++;
      if (srx_filt !== 1'b1 || srx_fall !== 1'b0 || enable !== 1'b0 || tick_cnt !== 4'd0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d got filt=%b fall=%b en=%b tick=%0d expected 1 0 0 0",
                 i, srx_filt, srx_fall, enable, tick_cnt);
      end
    end
    wb_rst_i = 1'b0;
    exp_tick = 4'd0;
    for (int i = 0; i < 4; i++) begin
      tick_clk();
      checks++;
      if (enable !== 1'b0 || tick_cnt !== 4'd0 || srx_fall !== 1'b0) begin
        errors++;
        $display("FAIL dl0_idle cyc=%0d got en=%b tick=%0d fall=%b expected 0 0 0",
                 i, enable, tick_cnt, srx_fall);
      end
    end
  endtask

  task automatic test_dl4();
    logic exp_en;
    load_dl(16'd4);
    checks++;
    if (enable !== 1'b0) begin
      errors++;
      $display("FAIL dl4_load_cycle got en=%b expected 0", enable);
    end
    for (int n = 1; n <= 12; n++) begin
      tick_clk();
      exp_en = (n % 4 == 0);
      if (exp_en) exp_tick = exp_tick + 4'd1;
      checks++;
      if (enable !== exp_en || tick_cnt !== exp_tick) begin
        errors++;
        $display("FAIL dl4_period n=%0d got en=%b tick=%0d expected en=%b tick=%0d",
                 n, enable, tick_cnt, exp_en, exp_tick);
      end
    end
  endtask

  task automatic test_dl1_wrap();
    load_dl(16'd1);
    checks++;
    if (enable !== 1'b0 || tick_cnt !== exp_tick) begin
      errors++;
      $display("FAIL dl1_load_cycle got en=%b tick=%0d expected en=0 tick=%0d",
               enable, tick_cnt, exp_tick);
    end
    for (int n = 1; n <= 16; n++) begin
      tick_clk();
      exp_tick = exp_tick + 4'd1;
      checks++;
      if (enable !== 1'b1 || tick_cnt !== exp_tick) begin
        errors++;
        $display("FAIL dl1_continuous n=%0d got en=%b tick=%0d expected en=1 tick=%0d",
                 n, enable, tick_cnt, exp_tick);
      end
    end
    load_dl(16'd0);
    for (int n = 0; n < 4; n++) begin
      checks++;
      if (enable !== 1'b0 || tick_cnt !== exp_tick) begin
        errors++;
        $display("FAIL dl0_frozen n=%0d got en=%b tick=%0d expected en=0 tick=%0d",
                 n, enable, tick_cnt, exp_tick);
      end
      tick_clk();
    end
  endtask

  task automatic test_glitch();
    logic pad_seq[$];
    logic exp_seq[$];
    logic exp_f, prev_exp, exp_fall;
    int   falls;
    repeat (4) begin pad_seq.push_back(1'b1); exp_seq.push_back(1'b1); end
    pad_seq.push_back(1'b0); exp_seq.push_back(1'b1);
    repeat (6) begin pad_seq.push_back(1'b1); exp_seq.push_back(1'b1); end
    repeat (5) begin pad_seq.push_back(1'b0); exp_seq.push_back(1'b0); end
    repeat (8) begin pad_seq.push_back(1'b1); exp_seq.push_back(1'b1); end
    exp_q.delete();
    repeat (3) exp_q.push_back(1'b1);
    prev_exp = 1'b1;
    falls = 0;
    for (int i = 0; i < pad_seq.size(); i++) begin
      drive_pad(pad_seq[i], exp_seq[i]);
      exp_f    = exp_q.pop_front();
      exp_fall = prev_exp & ~exp_f;
      prev_exp = exp_f;
      if (srx_fall === 1'b1) falls++;
      checks++;
      if (srx_filt !== exp_f || srx_fall !== exp_fall) begin
        errors++;
        $display("FAIL glitch_filter i=%0d got filt=%b fall=%b expected filt=%b fall=%b",
                 i, srx_filt, srx_fall, exp_f, exp_fall);
      end
    end
    checks++;
    if (falls != 1) begin
      errors++;
      $display("FAIL glitch_fall_count got %0d expected 1", falls);
    end
  endtask

  task automatic test_toggle();
    logic pad_seq[$];
    logic exp_f, prev_exp, exp_fall;
    int   falls;
    repeat (6) begin
      pad_seq.push_back(1'b1); pad_seq.push_back(1'b1);
      pad_seq.push_back(1'b0); pad_seq.push_back(1'b0);
    end
    repeat (6) pad_seq.push_back(1'b1);
    exp_q.delete();
    repeat (3) exp_q.push_back(1'b1);
    prev_exp = 1'b1;
    falls = 0;
    for (int i = 0; i < pad_seq.size(); i++) begin
      drive_pad(pad_seq[i], pad_seq[i]);
      exp_f    = exp_q.pop_front();
      exp_fall = prev_exp & ~exp_f;
      prev_exp = exp_f;
      if (srx_fall === 1'b1) falls++;
      checks++;
      if (srx_filt !== exp_f || srx_fall !== exp_fall) begin
        errors++;
        $display("FAIL toggle_follow i=%0d got filt=%b fall=%b expected filt=%b fall=%b",
                 i, srx_filt, srx_fall, exp_f, exp_fall);
      end
    end
    checks++;
    if (falls != 6) begin
      errors++;
      $display("FAIL toggle_fall_count got %0d expected 6", falls);
    end
  endtask

  task automatic test_load_at_terminal();
    logic exp_en;
    load_dl(16'd8);
    for (int n = 1; n <= 15; n++) begin
      tick_clk();
      exp_en = (n == 8);
      if (exp_en) exp_tick = exp_tick + 4'd1;
      checks++;
      if (enable !== exp_en || tick_cnt !== exp_tick) begin
        errors++;
        $display("FAIL dl8_period n=%0d got en=%b tick=%0d expected en=%b tick=%0d",
                 n, enable, tick_cnt, exp_en, exp_tick);
      end
    end
    load_dl(16'd3);
    checks++;
    if (enable !== 1'b0 || tick_cnt !== exp_tick) begin
      errors++;
      $display("FAIL load_wins_tc got en=%b tick=%0d expected en=0 tick=%0d",
               enable, tick_cnt, exp_tick);
    end
    for (int n = 1; n <= 9; n++) begin
      tick_clk();
      exp_en = (n % 3 == 0);
      if (exp_en) exp_tick = exp_tick + 4'd1;
      checks++;
      if (enable !== exp_en || tick_cnt !== exp_tick) begin
        errors++;
        $display("FAIL dl3_period n=%0d got en=%b tick=%0d expected en=%b tick=%0d",
                 n, enable, tick_cnt, exp_en, exp_tick);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_en;
    srx_pad_i = 1'b0;
    load_dl(16'd8);
    for (int n = 1; n <= 10; n++) begin
      tick_clk();
      exp_en = (n == 8);
      if (exp_en) exp_tick = exp_tick + 4'd1;
      checks++;
      if (enable !== exp_en) begin
        errors++;
        $display("FAIL mid_precount n=%0d got en=%b expected %b", n, enable, exp_en);
      end
    end
    checks++;
    if (srx_filt !== 1'b0) begin
      errors++;
      $display("FAIL mid_filt_low got %b expected 0", srx_filt);
    end
    wb_rst_i = 1'b1; srx_pad_i = 1'b1;
    tick_clk();
    wb_rst_i = 1'b0;
    exp_tick = 4'd0;
    checks++;
    if (srx_filt !== 1'b1 || srx_fall !== 1'b0 || enable !== 1'b0 || tick_cnt !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset got filt=%b fall=%b en=%b tick=%0d expected 1 0 0 0",
               srx_filt, srx_fall, enable, tick_cnt);
    end
    for (int n = 1; n <= 9; n++) begin
      tick_clk();
      exp_en = (n == 1 || n == 9);
      if (exp_en) exp_tick = exp_tick + 4'd1;
      checks++;
      if (enable !== exp_en || tick_cnt !== exp_tick || srx_filt !== 1'b1 || srx_fall !== 1'b0) begin
        errors++;
        $display("FAIL post_reset n=%0d got en=%b tick=%0d filt=%b fall=%b expected en=%b tick=%0d filt=1 fall=0",
                 n, enable, tick_cnt, srx_filt, srx_fall, exp_en, exp_tick);
      end
    end
  endtask

  task automatic test_reset_stopped();
    @(negedge clk);
    clk_run  = 1'b0;
    wb_rst_i = 1'b1;
    #40;
    checks++;
    if (enable !== 1'b1 || tick_cnt !== exp_tick) begin
      errors++;
      $display("FAIL stopped_reset_no_effect got en=%b tick=%0d expected en=1 tick=%0d",
               enable, tick_cnt, exp_tick);
    end
    clk_run = 1'b1;
    tick_clk();
    wb_rst_i = 1'b0;
    exp_tick = 4'd0;
    checks++;
    if (enable !== 1'b0 || tick_cnt !== 4'd0) begin
      errors++;
      $display("FAIL stopped_reset_edge got en=%b tick=%0d expected en=0 tick=0", enable, tick_cnt);
    end
    tick_clk();
    checks++;
    if (enable !== 1'b1 || tick_cnt !== 4'd1) begin
      errors++;
      $display("FAIL first_tick_after_reset got en=%b tick=%0d expected en=1 tick=1", enable, tick_cnt);
    end
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    srx_pad_i = 1'b1;
    dl        = '0;
    dl_load   = 1'b0;
    exp_tick  = 4'd0;
    test_reset();
    test_dl4();
    test_dl1_wrap();
    test_glitch();
    test_toggle();
    test_load_at_terminal();
    test_reset_mid();
    test_reset_stopped();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
- Upstream stage of the UART receive path.
- Conditions the raw asynchronous serial input: synchronizer, then 3-sample majority glitch filter.
- Generates the 16x oversampling `enable` tick from the programmed divisor latch.
- Outputs feed the receiver's `srx_pad_i` and `enable` inputs directly. Also provides a filtered start-edge pulse and a baud-tick count for status logic.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops on srx_pad_i; legal range 2..4.
- DL_W, 16, width of the divisor latch and the baud counter.

Ports:
- clk  input  1  system clock.
- wb_rst_i  input  1  reset, synchronous, active-high; sampled only on the rising edge of clk.
- srx_pad_i  input  1  raw asynchronous serial line; idles high.
- dl  input  DL_W  divisor latch value; one enable period = dl clk cycles.
- dl_load  input  1  one-cycle pulse when the divisor latch is written.
- srx_filt  output  1  synchronized, majority-filtered serial line.
- srx_fall  output  1  one-cycle pulse on a filtered 1->0 transition.
- enable  output  1  one-cycle baud tick (16x bit rate).
- tick_cnt  output  4  free-running count of enable ticks, modulo 16.

Behaviour:
- Clocking and reset
  - One clock: clk. Reset is synchronous and active-high (wb_rst_i).
  - Reset values: sync chain all 1; filter history all 1; srx_filt=1; srx_fall=0; enable=0; tick_cnt=0; baud counter=0.
  - Reset asserted mid-operation takes effect at the next clk edge and overrides dl_load.
- Synchronizer
  - srx_pad_i passes through SYNC_STAGES flops. Output is s_sync.
- Filter
  - Two history registers: h0 <= s_sync; h1 <= h0.
  - srx_filt <= majority(s_sync, h0, h1), registered.
  - Latency from a stable pad change to srx_filt: SYNC_STAGES+2 clk edges (4 at default).
  - A pad pulse of 1 clk is always suppressed. A pulse of >=2 clk passes, with length preserved to within 1 cycle.
- srx_fall
  - Asserted for exactly the first cycle in which srx_filt=0 after srx_filt=1.
  - Derived from srx_filt and a registered copy of it.
  - Never asserted in the cycle after reset.
- Baud counter (DL_W bits, counts down)
  - dl==0: counter held at 0; enable held 0; tick_cnt frozen.
  - dl==1: enable=1 every cycle.
  - dl>=2, normal operation: when the counter==0, enable is asserted for that cycle and the counter reloads dl-1. Otherwise the counter decrements.
  - Resulting enable period is exactly dl cycles. enable is a registered output.
  - After reset with dl>=2 stable: counter starts at 0, so the first enable occurs on the 1st cycle after reset release; the period is dl thereafter.
- dl_load
  - The counter loads dl-1 (0 if dl==0) and enable is forced 0 that cycle.
  - The next enable occurs dl cycles after the dl_load cycle.
  - dl_load coinciding with a terminal count: the load wins and no tick is emitted.
- tick_cnt
  - Increments by 1 on each enable. Wraps 15->0.
  - Not cleared by dl_load; cleared only by reset.
- Arithmetic
  - dl-1 is computed in DL_W bits and guarded so dl==0 never underflows.
  - The counter never decrements below 0.

Test Plan:
- Reset with dl=0, pad=1 -> srx_filt=1, srx_fall=0, enable=0, tick_cnt=0 held for 20 cycles.
- dl=4 via dl_load -> enable high on cycles 4, 8, 12 after the load, low otherwise; tick_cnt 1, 2, 3. dl=1 -> enable continuously high, tick_cnt wraps 15->0 after 16 cycles.
- Pad low for 1 cycle -> srx_filt stays 1, srx_fall never asserts. Pad low for 5 cycles -> srx_filt=0 exactly 4 edges after the pad falls, lasts 5 cycles, single srx_fall pulse in the first low cycle.
- dl=8 running; dl_load with dl=3 issued on the same cycle as the terminal count -> no enable that cycle; next enable 3 cycles later; period 3 thereafter.
- wb_rst_i asserted for 1 cycle while srx_filt=0 and the counter is mid-count -> next cycle srx_filt=1, counter=0, tick_cnt=0. Asserting reset while the clock is stopped has no effect until the next edge.
- Pad toggling every 2 cycles (1,1,0,0,...) -> srx_filt follows with 4-cycle latency; no extra srx_fall pulses beyond one per falling edge.
